// File: rtl/reg_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : reg_share_arb
// Description : Round-robin arbiter feeding one shared capture register.
//               Optional REG_SHARE_ARB_LOCK_EN adds req_lock (pointer holds).
// Revision    : 1.0 - initial release
// ============================================================================
module reg_share_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NREQ-1:0]                         req_valid,
    input  logic [NREQ*DW-1:0]                      req_data,
`ifdef REG_SHARE_ARB_LOCK_EN
    input  logic [NREQ-1:0]                         req_lock,
`endif
    output logic [NREQ-1:0]                         req_ready,
    output logic                                    out_valid,
    output logic [DW-1:0]                           out_data,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] out_src,
    input  logic                                    out_ready
);

    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [SW-1:0]   r_rr_ptr;
    logic [SW-1:0]   r_out_src;
    logic [DW-1:0]   r_out_data;
    logic            w_found;
    logic [SW-1:0]   w_sel;
    logic [NREQ-1:0] w_grant;
    logic [DW-1:0]   w_sel_data;
    logic            w_capture;
    logic            w_release;
    logic [SW-1:0]   w_src_inc;
    logic [SW-1:0]   w_ptr_nxt;

    // Two passes give the wrapped scan: indices at/above the pointer first,
    // then the whole vector from 0 if nothing above the pointer was valid.
    always_comb begin
        w_found    = 1'b0;
        w_sel      = '0;
        w_grant    = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (i >= int'(r_rr_ptr))) begin
                w_found    = 1'b1;
                w_sel      = SW'(i);
                w_grant[i] = 1'b1;
                w_sel_data = req_data[i*DW +: DW];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i]) begin
                w_found    = 1'b1;
                w_sel      = SW'(i);
                w_grant[i] = 1'b1;
                w_sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        req_ready   = '0;
        case (r_state)
            S_IDLE: begin
                if (!rst && w_found) begin
                    req_ready   = w_grant;
                    w_capture   = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (out_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_src_inc = (r_out_src == SW'(NREQ-1)) ? '0 : r_out_src + 1'b1;
`ifdef REG_SHARE_ARB_LOCK_EN
    assign w_ptr_nxt = req_lock[r_out_src] ? r_out_src : w_src_inc;
`else
    assign w_ptr_nxt = w_src_inc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_src  <= '0;
            r_rr_ptr   <= '0;
        end else if (w_capture) begin
            r_out_data <= w_sel_data;
            r_out_src  <= w_sel;
        end else if (w_release) begin
            r_rr_ptr   <= w_ptr_nxt;
        end
    end

    assign out_valid = (r_state == S_BUSY);
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule
`default_nettype wire

// File: doc/reg_share_arb.md
REG_SHARE_ARB -- requirements
Module: reg_share_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the capture register (legal range 2..16).
REQ-002 SHALL have parameter DW, default 8, width of the shared data register.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester data-valid; bit i belongs to requester i.
REQ-006 SHALL have port req_data  input  NREQ*DW  packed request data; requester i in bits [i*DW +: DW].
REQ-007 SHALL have port req_ready  output  NREQ  one-hot-or-zero grant/accept strobe.
REQ-008 SHALL have port out_valid  output  1  shared register holds a captured word.
REQ-009 SHALL have port out_data  output  DW  shared register contents.
REQ-010 SHALL have port out_src  output  max(1,$clog2(NREQ))  index of the requester whose word is in out_data.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data.

Function
REQ-012 SHALL implement a 2-state FSM: IDLE (register empty), BUSY (register full, out_valid=1).
REQ-013 In IDLE with any req_valid bit set, SHALL select the first set index scanning upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
REQ-014 In IDLE, req_ready SHALL be combinational: only the selected bit high, and only if its req_valid is high; all zero otherwise.
REQ-015 On a clock edge with req_valid[g] & req_ready[g], SHALL load out_data <= req_data[g], out_src <= g, out_valid <= 1, state -> BUSY (capture latency 1 cycle).
REQ-016 In BUSY, req_ready SHALL be all zero, and out_data and out_src SHALL stay stable until handshake.
REQ-017 In BUSY, on out_valid & out_ready, SHALL clear out_valid, state -> IDLE, rr_ptr <= (out_src+1) mod NREQ; out_data/out_src hold last value.
REQ-018 No capture SHALL occur in the handshake cycle; throughput is at most one word per 2 cycles.
REQ-019 out_ready in IDLE SHALL be ignored; req_valid dropping while in BUSY SHALL have no effect.
REQ-020 rr_ptr SHALL wrap from NREQ-1 to 0; for non-power-of-2 NREQ, rr_ptr SHALL never take a value >= NREQ.
REQ-021 Starvation-free: any requester holding req_valid SHALL be granted within NREQ grants.

Reset
REQ-022 With rst high at a clock edge: state=IDLE, out_valid=0, out_data=0, out_src=0, rr_ptr=0.
REQ-023 While rst is high, req_ready SHALL be forced to all zero.
REQ-024 Reset during BUSY SHALL discard the held word; no handshake is reported for it.

Configuration
REQ-025 Macro REG_SHARE_ARB_LOCK_EN SHALL, when defined, add input port req_lock (NREQ bits).
REQ-026 With REG_SHARE_ARB_LOCK_EN, at completion (REQ-017) with req_lock[out_src]=1, rr_ptr SHALL be set to out_src instead of out_src+1.
REQ-027 Without REG_SHARE_ARB_LOCK_EN, the req_lock port SHALL NOT exist and behaviour is exactly REQ-017.

Verification
REQ-028 Reset, then req_valid=4'b0000 for 10 cycles -> req_ready=0, out_valid=0, out_data=0 throughout.
REQ-029 NREQ=4, req_valid=4'b1111 held, out_ready=1 always -> out_src sequence 0,1,2,3,0; out_valid high every other cycle.
REQ-030 Single requester 2, req_data[2]=8'hA5, out_ready=0 for 5 cycles -> out_valid=1, out_data=8'hA5, out_src=2 stable; req_ready=0 during hold; one transfer when out_ready=1.
REQ-031 rst pulsed 1 cycle while BUSY with out_data=8'h3C -> next cycle out_valid=0, out_data=0, rr_ptr=0; requester 0 granted first afterwards.
REQ-032 NREQ=3, req_valid=3'b111 -> out_src 0,1,2,0 (wrap, no index 3).
REQ-033 LOCK_EN defined, req_lock[1]=1, req_valid=4'b0011 -> after first grant to 0, requester 1 granted on every subsequent transfer until req_lock[1]=0, then 0 next.
